atm_txn_ctrl: RTL and testbench

Transaction controller sitting directly upstream of the account counter. It turns operator button presses and a denomination selector into single-cycle `increment`/`decrement` strobes with an 8-bit `amount`. It then reads back the counter's `count` and its overflow and insufficient-funds flags to report each transaction as succeeded or failed. Includes input synchronisation, edge detection, an inactivity timeout and a one-transaction-at-a-time handshake.

---
 rtl/atm_pkg.sv | 47 ++++
 rtl/atm_txn_ctrl_if.sv | 36 +++
 rtl/btn_sync_edge.sv | 27 ++
 rtl/atm_txn_ctrl.sv | 150 +++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types, error codes and denomination lookup for the ATM transaction controller
package atm_pkg;

  localparam int NUM_DENOMS = 6;

  // Encodings are exported on the debug state port, so keep them fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } atm_state_e;

  typedef enum logic {
    MODE_DEP = 1'b0,
    MODE_WDR = 1'b1
  } atm_mode_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_INSUFF   = 2'd2;
  localparam logic [1:0] ERR_INVALID  = 2'd3;

  // Dollar value of a selector index; invalid indices map to 0 and are never latched.
  function automatic logic [7:0] denom_value(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0:    val = 8'd1;
      3'd1:    val = 8'd5;
      3'd2:    val = 8'd10;
      3'd3:    val = 8'd20;
      3'd4:    val = 8'd50;
      3'd5:    val = 8'd100;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

  function automatic logic denom_valid(input logic [2:0] idx);
    return (int'(idx) < NUM_DENOMS);
  endfunction

endpackage

// File: rtl/atm_txn_ctrl_if.sv
// rtl/atm_txn_ctrl_if.sv - operator/counter bundle between the transaction controller and its environment
interface atm_txn_ctrl_if;

  logic       btn_deposit;
  logic       btn_withdraw;
  logic       btn_confirm;
  logic       btn_cancel;
  logic [2:0] denom_sel;
  logic [7:0] count;
  logic       led_overflow;
  logic       led_insufficient;

  logic       increment;
  logic       decrement;
  logic [7:0] amount;
  logic       busy;
  logic       txn_ok;
  logic       txn_err;
  logic [1:0] err_code;
  logic [2:0] state;

  // Controller side: consumes buttons and counter flags, drives strobes and status.
  modport master (
    input  btn_deposit, btn_withdraw, btn_confirm, btn_cancel,
    input  denom_sel, count, led_overflow, led_insufficient,
    output increment, decrement, amount, busy, txn_ok, txn_err, err_code, state
  );

  // Operator panel plus account counter side.
  modport slave (
    output btn_deposit, btn_withdraw, btn_confirm, btn_cancel,
    output denom_sel, count, led_overflow, led_insufficient,
    input  increment, decrement, amount, busy, txn_ok, txn_err, err_code, state
  );

endinterface

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - multi-flop synchroniser followed by a rising-edge detector
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw level through the synchroniser and remember the last synced value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/atm_txn_ctrl.sv
// rtl/atm_txn_ctrl.sv - turns button edges into single increment/decrement strobes and reports the outcome
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          clk,
  input  logic          reset,
  atm_txn_ctrl_if.master bus
);

  // Counter only has to reach TIMEOUT_CYCLES-1: the timeout fires on that cycle.
  localparam int         TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic dep_rise, wdr_rise, cfm_rise, cnl_rise;
  logic any_rise;
  logic timed_out;

  atm_state_e    state_q, state_d;
  atm_mode_e     mode_q, mode_d;
  logic [7:0]    amount_q, amount_d;
  logic [1:0]    err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // The decision is driven purely by the counter flags; the total is not needed here.
  logic unused_count;
  assign unused_count = ^bus.count;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dep (
    .clk(clk), .reset(reset), .btn_i(bus.btn_deposit), .rise_o(dep_rise)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wdr (
    .clk(clk), .reset(reset), .btn_i(bus.btn_withdraw), .rise_o(wdr_rise)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cfm (
    .clk(clk), .reset(reset), .btn_i(bus.btn_confirm), .rise_o(cfm_rise)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cnl (
    .clk(clk), .reset(reset), .btn_i(bus.btn_cancel), .rise_o(cnl_rise)
  );

  assign any_rise  = dep_rise | wdr_rise | cfm_rise | cnl_rise;
  assign timed_out = (tmo_q == TMO_LAST) && !any_rise;

  // Register the FSM, the latched transaction context and the inactivity counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_DEP;
      amount_q <= 8'd0;
      err_q    <= ERR_NONE;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      amount_q <= amount_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic; cancel always wins over confirm, and edges outside IDLE/SELECT/CONFIRM are dropped.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    amount_d = amount_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        // Exactly one mode edge is accepted; both together are ambiguous and ignored.
        if (dep_rise ^ wdr_rise) begin
          state_d = ST_SELECT;
          mode_d  = dep_rise ? MODE_DEP : MODE_WDR;
          err_d   = ERR_NONE;
        end
      end
      ST_SELECT: begin
        if (cnl_rise) begin
          state_d = ST_IDLE;
        end else if (cfm_rise) begin
          if (denom_valid(bus.denom_sel)) begin
            amount_d = denom_value(bus.denom_sel);
            state_d  = ST_CONFIRM;
          end else begin
            err_d   = ERR_INVALID;
            state_d = ST_ERROR;
          end
        end else if (timed_out) begin
          err_d   = ERR_INVALID;
          state_d = ST_ERROR;
        end
      end
      ST_CONFIRM: begin
        if (cnl_rise) begin
          state_d = ST_IDLE;
        end else if (cfm_rise) begin
          state_d = ST_ISSUE;
        end else if (timed_out) begin
          err_d   = ERR_INVALID;
          state_d = ST_ERROR;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (mode_q == MODE_DEP) begin
          if (bus.led_overflow) begin
            err_d   = ERR_OVERFLOW;
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          if (bus.led_insufficient) begin
            err_d   = ERR_INSUFF;
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Inactivity counter: restarts on any state change or button edge, only runs while awaiting input.
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && !any_rise &&
        ((state_q == ST_SELECT) || (state_q == ST_CONFIRM))) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Outputs decode straight from registered state so reset clears them immediately.
  assign bus.increment = (state_q == ST_ISSUE) && (mode_q == MODE_DEP);
  assign bus.decrement = (state_q == ST_ISSUE) && (mode_q == MODE_WDR);
  assign bus.amount    = amount_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.txn_ok    = (state_q == ST_DONE);
  assign bus.txn_err   = (state_q == ST_ERROR);
  assign bus.err_code  = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// tb/tb_atm_txn_ctrl.sv - directed self-checking bench for atm_txn_ctrl with a behavioural account counter
module tb_atm_txn_ctrl;
  import atm_pkg::*;

  localparam int TMO = 1000;
  localparam logic [3:0] B_DEP = 4'b0001;
  localparam logic [3:0] B_WDR = 4'b0010;
  localparam logic [3:0] B_CFM = 4'b0100;
  localparam logic [3:0] B_CNL = 4'b1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_txn_ctrl_if bus();

  atm_txn_ctrl #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int inc_cnt = 0, dec_cnt = 0, ok_cnt = 0, err_cnt = 0;
  int overlap_cnt = 0, long_cnt = 0;
  logic inc_prev = 1'b0, dec_prev = 1'b0;

  logic       load_req = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] acct = 8'd0;
  logic       lov = 1'b0, lins = 1'b0;

  assign bus.count            = acct;
  assign bus.led_overflow     = lov;
  assign bus.led_insufficient = lins;

  // Account counter model: saturating refusal with flags, updated on the strobe edge.
  always @(posedge clk) begin
    if (load_req) begin
      acct <= load_val; lov <= 1'b0; lins <= 1'b0;
    end else if (bus.increment) begin
      lins <= 1'b0;
      if ({1'b0, acct} + {1'b0, bus.amount} > 9'd255) lov <= 1'b1;
      else begin acct <= acct + bus.amount; lov <= 1'b0; end
    end else if (bus.decrement) begin
      lov <= 1'b0;
      if (bus.amount > acct) lins <= 1'b1;
      else begin acct <= acct - bus.amount; lins <= 1'b0; end
    end
  end

  // Pulse monitor.
  always @(posedge clk) begin
    if (bus.increment) inc_cnt <= inc_cnt + 1;
    if (bus.decrement) dec_cnt <= dec_cnt + 1;
    if (bus.txn_ok)    ok_cnt  <= ok_cnt + 1;
    if (bus.txn_err)   err_cnt <= err_cnt + 1;
    if (bus.increment && bus.decrement) overlap_cnt <= overlap_cnt + 1;
    if ((bus.increment && inc_prev) || (bus.decrement && dec_prev)) long_cnt <= long_cnt + 1;
    inc_prev <= bus.increment;
    dec_prev <= bus.decrement;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One-cycle button pulse; returns at the negedge where the FSM has just reacted.
  task automatic press(input logic [3:0] m);
    bus.btn_deposit  = m[0];
    bus.btn_withdraw = m[1];
    bus.btn_confirm  = m[2];
    bus.btn_cancel   = m[3];
    @(negedge clk);
    bus.btn_deposit  = 1'b0;
    bus.btn_withdraw = 1'b0;
    bus.btn_confirm  = 1'b0;
    bus.btn_cancel   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    load_val = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // From ISSUE, wait (bounded) for the result pulse; returns at that negedge.
  task automatic wait_result(output logic ok, output logic err, output int cyc);
    cyc = 0;
    while (!(bus.txn_ok || bus.txn_err) && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    ok  = bus.txn_ok;
    err = bus.txn_err;
  endtask

  logic r_ok, r_err;
  int   r_cyc;

  initial begin
    reset = 1'b0;
    bus.btn_deposit = 1'b0; bus.btn_withdraw = 1'b0;
    bus.btn_confirm = 1'b0; bus.btn_cancel = 1'b0;
    bus.denom_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_strobes", {bus.increment, bus.decrement}, 0);
    check("rst_amount", bus.amount, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_pulses", {bus.txn_ok, bus.txn_err}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Deposit $20 into an empty account.
    load(8'd0);
    bus.denom_sel = 3'd3;
    press(B_DEP);
    check("t1_select", bus.state, 1);
    check("t1_busy", bus.busy, 1);
    press(B_CFM);
    check("t1_confirm", bus.state, 2);
    check("t1_amount", bus.amount, 20);
    press(B_CFM);
    check("t1_issue", bus.state, 3);
    check("t1_increment", bus.increment, 1);
    check("t1_no_decrement", bus.decrement, 0);
    @(negedge clk);
    check("t1_wait", bus.state, 4);
    check("t1_inc_one_cycle", bus.increment, 0);
    @(negedge clk);
    check("t1_check", bus.state, 5);
    @(negedge clk);
    check("t1_txn_ok", bus.txn_ok, 1);
    check("t1_done", bus.state, 6);
    @(negedge clk);
    check("t1_idle", bus.state, 0);
    check("t1_ok_cleared", bus.txn_ok, 0);
    check("t1_acct", acct, 20);
    check("t1_inc_cnt", inc_cnt, 1);

    // Deposit $10 on 250 overflows.
    load(8'd250);
    bus.denom_sel = 3'd2;
    press(B_DEP); press(B_CFM); press(B_CFM);
    check("t2_increment", bus.increment, 1);
    wait_result(r_ok, r_err, r_cyc);
    check("t2_latency", r_cyc, 3);
    check("t2_txn_err", {r_ok, r_err}, 2'b01);
    check("t2_err_code", bus.err_code, 1);
    check("t2_acct", acct, 250);

    // Withdraw $5 from 4 is refused, then $1 succeeds.
    load(8'd4);
    bus.denom_sel = 3'd1;
    press(B_WDR); press(B_CFM); press(B_CFM);
    check("t3_decrement", bus.decrement, 1);
    check("t3_no_increment", bus.increment, 0);
    wait_result(r_ok, r_err, r_cyc);
    check("t3_txn_err", {r_ok, r_err}, 2'b01);
    check("t3_err_code", bus.err_code, 2);
    @(negedge clk);
    check("t3_err_sticky", bus.err_code, 2);
    bus.denom_sel = 3'd0;
    press(B_WDR);
    check("t3_err_cleared", bus.err_code, 0);
    press(B_CFM); press(B_CFM);
    wait_result(r_ok, r_err, r_cyc);
    check("t3_latency", r_cyc, 3);
    check("t3_txn_ok", {r_ok, r_err}, 2'b10);
    check("t3_acct", acct, 3);
    check("t3_dec_cnt", dec_cnt, 2);

    // Invalid selector at first confirm.
    @(negedge clk);
    bus.denom_sel = 3'd6;
    press(B_DEP); press(B_CFM);
    check("t4_error_state", bus.state, 7);
    check("t4_txn_err", bus.txn_err, 1);
    check("t4_err_code", bus.err_code, 3);
    @(negedge clk);
    check("t4_idle", bus.state, 0);
    check("t4_no_strobe", inc_cnt + dec_cnt, 4);

    // Cancel in CONFIRM, selector change ignored; then cancel+confirm together in SELECT.
    bus.denom_sel = 3'd1;
    press(B_DEP);
    check("t5_err_cleared", bus.err_code, 0);
    press(B_CFM);
    check("t5_confirm", bus.state, 2);
    bus.denom_sel = 3'd5;
    repeat (2) @(negedge clk);
    check("t5_amount_held", bus.amount, 5);
    press(B_CNL);
    check("t5_cancel_idle", bus.state, 0);
    press(B_DEP);
    press(B_CFM | B_CNL);
    check("t5_cancel_wins", bus.state, 0);
    @(negedge clk);
    check("t5_strobes", inc_cnt + dec_cnt, 4);
    check("t5_ok_cnt", ok_cnt, 2);
    check("t5_err_cnt", err_cnt, 3);

    // Inactivity timeout in SELECT.
    press(B_DEP);
    check("t6_select", bus.state, 1);
    repeat (TMO - 1) @(negedge clk);
    check("t6_still_select", bus.state, 1);
    @(negedge clk);
    check("t6_timeout_state", bus.state, 7);
    check("t6_timeout_err", bus.err_code, 3);
    check("t6_timeout_pulse", bus.txn_err, 1);
    @(negedge clk);

    // Reset during WAIT aborts; simultaneous mode edges ignored afterwards.
    load(8'd0);
    bus.denom_sel = 3'd0;
    press(B_DEP); press(B_CFM); press(B_CFM);
    @(negedge clk);
    check("t7_wait", bus.state, 4);
    #2 reset = 1'b0;
    #1;
    check("t7_rst_state", bus.state, 0);
    check("t7_rst_busy", bus.busy, 0);
    check("t7_rst_outputs", {bus.increment, bus.decrement, bus.txn_ok, bus.txn_err}, 0);
    check("t7_rst_amount", bus.amount, 0);
    check("t7_rst_err", bus.err_code, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t7_no_ok", ok_cnt, 2);
    check("t7_err_cnt", err_cnt, 4);
    press(B_DEP | B_WDR);
    check("t7_both_ignored", bus.state, 0);
    @(negedge clk);
    check("t7_both_busy", bus.busy, 0);

    check("no_overlap", overlap_cnt, 0);
    check("no_long_strobe", long_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
